demux_stage: RTL and testbench



---
 rtl/demux_stage_pkg.sv | 13 +
 rtl/demux_stage_slot.sv | 29 ++
 rtl/demux_stage.sv | 85 ++++++++
 tb/tb_demux_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/demux_stage_pkg.sv
// Shared constants and types for the 1-to-16 registered demultiplexer stage.
package demux_stage_pkg;

    localparam int unsigned SIGN_WIDTH = 4;
    localparam int unsigned NUM_CH     = 2 ** SIGN_WIDTH;
    localparam int unsigned DATA_WIDTH = 32;

    typedef logic [SIGN_WIDTH-1:0] ch_idx_t;
    typedef logic [NUM_CH-1:0]     ch_mask_t;

    localparam logic [DATA_WIDTH-1:0] RST_DATA = '0;

endpackage

// File: rtl/demux_stage_slot.sv
// One output channel: data register plus valid flag with load/drain control.
module demux_stage_slot
    import demux_stage_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             take,
    input  logic [width-1:0] d,
    output logic [width-1:0] y,
    output logic             v
);

    // A load on the same edge as a take keeps the slot full with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= width'(RST_DATA);
            v <= 1'b0;
        end else if (load) begin
            y <= d;
            v <= 1'b1;
        end else if (v && take) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stage.sv
// Registered 1-to-16 demultiplexer with per-channel one-entry buffers and valid/ready handshakes.
module demux_stage
    import demux_stage_pkg::*;
#(
    parameter int unsigned width     = 32,
    parameter int unsigned signWidth = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [signWidth-1:0] s,
    input  logic [width-1:0]     d,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [NUM_CH-1:0]    out_valid,
    output logic [width-1:0]     y0,
    output logic [width-1:0]     y1,
    output logic [width-1:0]     y2,
    output logic [width-1:0]     y3,
    output logic [width-1:0]     y4,
    output logic [width-1:0]     y5,
    output logic [width-1:0]     y6,
    output logic [width-1:0]     y7,
    output logic [width-1:0]     y8,
    output logic [width-1:0]     y9,
    output logic [width-1:0]     y10,
    output logic [width-1:0]     y11,
    output logic [width-1:0]     y12,
    output logic [width-1:0]     y13,
    output logic [width-1:0]     y14,
    output logic [width-1:0]     y15
);

    ch_idx_t          sel;
    ch_mask_t         v;
    ch_mask_t         load;
    logic [width-1:0] y_arr [NUM_CH];

    assign sel = ch_idx_t'(s);

    // Ready looks only at the selected slot; a full slot being drained this cycle can refill.
    assign in_ready = !v[sel] || out_ready[sel];

    // One-hot load strobe for the accepted transfer.
    always_comb begin
        load = '0;
        if (in_valid && in_ready) begin
            load[sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_stage_slot #(
            .width (width)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .take  (out_ready[k]),
            .d     (d),
            .y     (y_arr[k]),
            .v     (v[k])
        );
    end

    assign out_valid = v;

    assign y0  = y_arr[0];
    assign y1  = y_arr[1];
    assign y2  = y_arr[2];
    assign y3  = y_arr[3];
    assign y4  = y_arr[4];
    assign y5  = y_arr[5];
    assign y6  = y_arr[6];
    assign y7  = y_arr[7];
    assign y8  = y_arr[8];
    assign y9  = y_arr[9];
    assign y10 = y_arr[10];
    assign y11 = y_arr[11];
    assign y12 = y_arr[12];
    assign y13 = y_arr[13];
    assign y14 = y_arr[14];
    assign y15 = y_arr[15];

endmodule

// File: tb/tb_demux_stage.sv
// Directed self-checking bench for demux_stage.
module tb_demux_stage;

    logic        clk;
    logic        rst_n;
    logic [3:0]  s;
    logic [31:0] d;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_ready;
    logic [15:0] out_valid;
    logic [31:0] ys [16];

    int checks;
    int errors;

    demux_stage #(
        .width     (32),
        .signWidth (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .y0 (ys[0]),  .y1 (ys[1]),  .y2 (ys[2]),  .y3 (ys[3]),
        .y4 (ys[4]),  .y5 (ys[5]),  .y6 (ys[6]),  .y7 (ys[7]),
        .y8 (ys[8]),  .y9 (ys[9]),  .y10(ys[10]), .y11(ys[11]),
        .y12(ys[12]), .y13(ys[13]), .y14(ys[14]), .y15(ys[15])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] ch, input logic [31:0] data);
        s        = ch;
        d        = data;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        s         = '0;
        d         = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_y0", ys[0], 32'h0);
        rst_n = 1'b1;
        step();

        // Single write to channel 5
        s = 4'd5; d = 32'hDEADBEEF; in_valid = 1'b1; out_ready = '0;
        #1;
        check("single_in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        #1;
        check("single_out_valid", 32'(out_valid), 32'h0020);
        check("single_y5", ys[5], 32'hDEADBEEF);
        check("single_blocked", 32'(in_ready), 32'h0);

        // Pass-through refill of a full channel that is draining
        d = 32'h12345678; in_valid = 1'b1; out_ready = 16'h0020;
        #1;
        check("pass_in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0; out_ready = '0;
        #1;
        check("pass_y5", ys[5], 32'h12345678);
        check("pass_out_valid", 32'(out_valid), 32'h0020);

        // Drain leaves data in place
        out_ready = 16'h0020;
        step();
        out_ready = '0;
        check("drain_out_valid", 32'(out_valid), 32'h0);
        check("drain_y5_retained", ys[5], 32'h12345678);

        // Fill all 16 channels
        for (int k = 0; k < 16; k++) write(4'(k), 32'(k));
        check("all_out_valid", 32'(out_valid), 32'h0000FFFF);
        for (int k = 0; k < 16; k++) begin
            s = 4'(k);
            #1;
            check($sformatf("all_y%0d", k), ys[k], 32'(k));
            check($sformatf("all_ready_s%0d", k), 32'(in_ready), 32'h0);
        end

        // Keep only 2 and 7 full
        out_ready = ~16'h0084;
        step();
        out_ready = '0;
        check("keep_2_7", 32'(out_valid), 32'h0084);

        // Blocked write to 2 while 7 drains
        s = 4'd2; d = 32'hAAAA5555; in_valid = 1'b1; out_ready = 16'h0080;
        #1;
        check("indep_in_ready", 32'(in_ready), 32'h0);
        step();
        in_valid = 1'b0; out_ready = '0;
        #1;
        check("indep_out_valid", 32'(out_valid), 32'h0004);
        check("indep_y2", ys[2], 32'h2);

        // Retarget from the blocked channel to an empty one
        s = 4'd7;
        #1;
        check("retarget_ready", 32'(in_ready), 32'h1);

        out_ready = 16'h0004;
        step();
        out_ready = '0;
        check("empty_again", 32'(out_valid), 32'h0);

        // Streaming on channel 11 with continuous consumer
        s = 4'd11; out_ready = 16'h0800;
        for (int i = 1; i <= 8; i++) begin
            d = 32'(i); in_valid = 1'b1;
            #1;
            check($sformatf("stream_ready%0d", i), 32'(in_ready), 32'h1);
            step();
            check($sformatf("stream_y11_%0d", i), ys[11], 32'(i));
            check($sformatf("stream_valid%0d", i), 32'(out_valid), 32'h0800);
        end
        in_valid = 1'b0;
        step();
        out_ready = '0;
        check("stream_drained", 32'(out_valid), 32'h0);

        // Asynchronous reset between edges
        write(4'd3, 32'h33333333);
        write(4'd9, 32'h99999999);
        check("pre_reset_valid", 32'(out_valid), 32'h0208);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_y3", ys[3], 32'h0);
        check("async_y9", ys[9], 32'h0);
        for (int k = 0; k < 16; k += 5) begin
            s = 4'(k);
            #1;
            check($sformatf("async_ready_s%0d", k), 32'(in_ready), 32'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_reset_valid", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
